// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory arbiter (response state, owner, byte-enable width)
package mem_arb_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - combinational two-way grant select; ptr names the side that wins a conflict
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t ptr,
    output logic   gnt_i,
    output logic   gnt_d
);

    assign gnt_d = req_d & (~req_i | (ptr == OWN_D));
    assign gnt_i = req_i & ~gnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one single-port sync memory; MEM_ARB_RR_EN enables round-robin on conflicts
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic        sel_i;
    logic        sel_d;
    owner_t      ptr;
    resp_state_t state;

    mem_arb_sel u_sel (
        .req_i (i_req),
        .req_d (d_req),
        .ptr   (ptr),
        .gnt_i (sel_i),
        .gnt_d (sel_d)
    );

    // Grants are masked while reset is held so nothing reaches the memory.
    assign i_gnt = sel_i & ~rst;
    assign d_gnt = sel_d & ~rst;

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_be    = d_gnt ? d_be : '0;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_gnt ? d_wdata : '0;

`ifdef MEM_ARB_RR_EN
    // After a conflict the loser gets priority on the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= OWN_D;
        end else if (i_req && d_req) begin
            ptr <= d_gnt ? OWN_I : OWN_D;
        end
    end
`else
    assign ptr = OWN_D;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else if (d_gnt && !d_we) begin
            state    <= RESP_D;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b1;
        end else if (i_gnt) begin
            state    <= RESP_I;
            i_rvalid <= 1'b1;
            d_rvalid <= 1'b0;
        end else begin
            state    <= IDLE;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end
    end

    assign i_rdata = (state == RESP_I) ? mem_rdata : '0;
    assign d_rdata = (state == RESP_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a 1-cycle sync memory model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int vec_count = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory initialised so that word at byte address A holds 0x1000_0000 + A.
    logic [31:0] mem [0:1023];
    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k * 4;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= mem[mem_addr[11:2]];
        end
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    task automatic drive(input vec_t v);
        i_req   = v.i_req;
        i_addr  = v.i_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_be    = v.d_be;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
    endtask

    // Address is checked only when a grant is expected, be/wdata only on expected writes.
    task automatic compare(input string name, input vec_t v);
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wdata, a_addr, a_wdata;
        logic [3:0]  e_be, a_be;
        logic [139:0] act, exp;
        e_en    = v.e_ig | v.e_dg;
        e_we    = v.e_dg & v.d_we;
        e_addr  = v.e_dg ? v.d_addr : (v.e_ig ? v.i_addr : 32'h0);
        e_be    = e_we ? v.d_be : 4'h0;
        e_wdata = e_we ? v.d_wdata : 32'h0;
        a_addr  = e_en ? mem_addr : 32'h0;
        a_be    = e_we ? mem_be : 4'h0;
        a_wdata = e_we ? mem_wdata : 32'h0;
        act = {i_gnt, d_gnt, mem_en, mem_we, a_addr, a_be, a_wdata,
               i_rvalid, i_rdata, d_rvalid, d_rdata};
        exp = {v.e_ig, v.e_dg, e_en, e_we, e_addr, e_be, e_wdata,
               v.e_irv, v.e_ird, v.e_drv, v.e_drd};
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got ig=%b dg=%b en=%b we=%b addr=%h be=%h wd=%h irv=%b ird=%h drv=%b drd=%h, want ig=%b dg=%b en=%b we=%b addr=%h be=%h wd=%h irv=%b ird=%h drv=%b drd=%h",
                     name, i_gnt, d_gnt, mem_en, mem_we, a_addr, a_be, a_wdata,
                     i_rvalid, i_rdata, d_rvalid, d_rdata,
                     v.e_ig, v.e_dg, e_en, e_we, e_addr, e_be, e_wdata,
                     v.e_irv, v.e_ird, v.e_drv, v.e_drd);
        end
    endtask

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t cvec [5];
    vec_t zv;

    initial begin
        //            ireq iaddr     dreq we be     daddr     dwdata        ig dg irv ird           drv drd
        vecs[0]  = '{0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vecs[1]  = '{1, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
        vecs[2]  = '{1, 32'h4,    0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 1, 32'h10000000, 0, 32'h0};
        vecs[3]  = '{1, 32'h8,    0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 1, 32'h10000004, 0, 32'h0};
        vecs[4]  = '{0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 1, 32'h10000008, 0, 32'h0};
        vecs[5]  = '{1, 32'h10,   1, 0, 4'hF, 32'h100, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0};
        vecs[6]  = '{1, 32'h10,   0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 32'h0,        1, 32'h10000100};
        vecs[7]  = '{0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 1, 32'h10000010, 0, 32'h0};
        vecs[8]  = '{0, 32'h0,    1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 1, 0, 32'h0,        0, 32'h0};
        vecs[9]  = '{0, 32'h0,    1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0};
        vecs[10] = '{0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        1, 32'h1000BEEF};
        vecs[11] = '{0, 32'h0,    1, 0, 4'hF, 32'h4,   32'h0,        0, 1, 0, 32'h0,        0, 32'h0};
        vecs[12] = '{1, 32'h8,    0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 32'h0,        1, 32'h10000004};
        vecs[13] = '{0, 32'h0,    1, 1, 4'hF, 32'h8,   32'h12345678, 0, 1, 1, 32'h10000008, 0, 32'h0};
        vecs[14] = '{0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vecs[15] = '{0, 32'h0,    1, 0, 4'hF, 32'h8,   32'h0,        0, 1, 0, 32'h0,        0, 32'h0};
        vecs[16] = '{0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        1, 32'h12345678};

`ifdef MEM_ARB_RR_EN
        cvec[0] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 0, 32'h0,        0, 32'h0};
        cvec[1] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 1, 0, 0, 32'h0,        1, 32'h10000040};
        cvec[2] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 1, 32'h10000020, 0, 32'h0};
        cvec[3] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 1, 0, 0, 32'h0,        1, 32'h10000040};
        cvec[4] = '{0, 32'h0,  0, 0, 4'h0, 32'h0,  32'h0, 0, 0, 1, 32'h10000020, 0, 32'h0};
`else
        cvec[0] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0};
        cvec[1] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 0, 32'h0, 1, 32'h10000040};
        cvec[2] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 0, 32'h0, 1, 32'h10000040};
        cvec[3] = '{1, 32'h20, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 0, 32'h0, 1, 32'h10000040};
        cvec[4] = '{0, 32'h0,  0, 0, 4'h0, 32'h0,  32'h0, 0, 0, 0, 32'h0, 1, 32'h10000040};
`endif
        zv = '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0};

        // Reset state: requests (including a write) must not leak through while rst is high.
        @(negedge clk);
        drive('{1, 32'h4, 1, 1, 4'hF, 32'h8, 32'h55, 0, 0, 0, 32'h0, 0, 32'h0});
        #1 compare("reset_hold", zv);
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[0]);
        #1 compare("reset_release_idle", vecs[0]);

        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            drive(vecs[n]);
            #1 compare($sformatf("vec%0d", n), vecs[n]);
        end

        // Reset with a fetch read in flight: the response must be discarded.
        @(negedge clk);
        drive('{1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0});
        #1 compare("rst_mid_grant", '{1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0});
        @(posedge clk);
        #1 rst = 1'b1;
        drive('{1, 32'h30, 1, 1, 4'hF, 32'h8, 32'h99, 0, 0, 0, 32'h0, 0, 32'h0});
        #1 compare("rst_mid_discard", zv);
        @(negedge clk);
        #1 compare("rst_mid_held", zv);
        @(negedge clk);
        rst = 1'b0;
        drive('{1, 32'h34, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0});
        #1 compare("rst_first_cycle", '{1, 32'h34, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0});
        @(negedge clk);
        drive(zv);
        #1 compare("rst_first_resp", '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 32'h10000034, 0, 32'h0});

        // Both requesters held for four cycles after reset restored the pointer.
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            drive(cvec[n]);
            #1 compare($sformatf("conflict%0d", n), cvec[n]);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 Port clk SHALL be input, 1 bit: single clock, rising-edge.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports i_req in 1, i_addr in ADDR_W, i_gnt out 1, i_rvalid out 1, i_rdata out DATA_W SHALL form the fetch (read-only) requester.
REQ-006 Ports d_req in 1, d_we in 1, d_be in 4, d_addr in ADDR_W, d_wdata in DATA_W, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W SHALL form the data-stage requester.
REQ-007 Ports mem_en out 1, mem_we out 1, mem_be out 4, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W SHALL drive one single-port synchronous memory with 1-cycle read latency.

Function
REQ-008 Grant SHALL be combinational in the request cycle; at most one of i_gnt/d_gnt high per cycle.
REQ-009 Granted requester's address/we/be/wdata SHALL be muxed combinationally to mem_*; mem_en = i_gnt | d_gnt; mem_we = d_gnt & d_we; fetch grants force mem_we=0.
REQ-010 Conflict (i_req & d_req) SHALL grant data side (fixed priority) when MEM_ARB_RR_EN is undefined.
REQ-011 Single request SHALL be granted immediately, back-to-back every cycle, no bubble.
REQ-012 Response FSM states: IDLE, RESP_I, RESP_D; next state = RESP_I after fetch grant, RESP_D after data read grant, IDLE otherwise (including data write grant).
REQ-013 In RESP_I, i_rvalid=1 and i_rdata=mem_rdata; in RESP_D, d_rvalid=1 and d_rdata=mem_rdata; in IDLE both rvalids 0.
REQ-014 Read latency SHALL be exactly 1 cycle grant-to-rvalid; writes SHALL produce no rvalid.
REQ-015 New grant in the same cycle as a response SHALL be allowed (pipelined); response and next grant are independent.
REQ-016 rdata outputs not in their RESP state SHALL be 0.
REQ-017 Requester holding req while not granted SHALL stay ungranted with no side effect; req drop before grant SHALL cancel silently.
REQ-018 A requester SHALL hold addr/we/be/wdata stable only during its grant cycle; no further hold required.

Reset
REQ-019 rst high SHALL force state IDLE, RR pointer to data side, and all registered outputs 0 asynchronously.
REQ-020 While rst high, i_gnt, d_gnt, mem_en, mem_we SHALL be 0 regardless of requests.
REQ-021 Reset asserted with a read in flight SHALL discard that response; no rvalid after deassertion for it.
REQ-022 First cycle after deassertion SHALL arbitrate normally.

Configuration
REQ-023 Macro MEM_ARB_RR_EN defined: conflicts SHALL alternate via 1-bit pointer (starts data side, flips to loser after each conflict grant; non-conflict grants leave it unchanged).
REQ-024 Macro MEM_ARB_RR_EN undefined: pointer SHALL not exist; fixed data priority per REQ-010.

Structure
REQ-025 Package mem_arb_pkg SHALL hold resp state enum (IDLE, RESP_I, RESP_D), owner enum (OWN_I, OWN_D), and BE_W=4.
REQ-026 Grant selection SHALL be sub-module mem_arb_sel (req_i, req_d, ptr -> gnt_i, gnt_d); FSM, muxing and pointer stay in mem_arbiter.

Verification
REQ-027 Fetch-only: i_req=1 at 0x0,0x4,0x8 three cycles -> i_gnt 3 cycles, i_rvalid cycles 2-4 with mem contents at 0x0,0x4,0x8.
REQ-028 Conflict fixed priority: i_req@0x10, d_req read@0x100 same cycle -> d_gnt=1, i_gnt=0; next cycle d_rvalid with word@0x100, i_gnt=1.
REQ-029 Data write then read: d_we=1, d_be=4'b0011, addr 0x200, wdata 0xDEADBEEF, then read 0x200 -> no rvalid after write; read returns low half 0xBEEF merged with prior upper bytes.
REQ-030 MEM_ARB_RR_EN: both req held 4 cycles -> grant order D,I,D,I; response owners match one cycle later.
REQ-031 Reset mid-read: grant fetch read, assert rst next edge -> i_rvalid stays 0, state IDLE, mem_en=0 during reset.
REQ-032 Back-to-back mixed: D read, I read, D write consecutive cycles -> rvalids D then I, none for the write, mem_we high only in cycle 3.
